// File: rtl/packed_poly_mac_stream.sv
// Packed polynomial multiply stage: holds one A chunk and streams secret chunks against it,
// producing the (2*LANES-1)-term product mod 2^COEF_W through a 2-stage pipeline with backpressure.
module packed_poly_mac_stream #(
  parameter int unsigned DEPTH    = 784,
  parameter int unsigned LANES    = 4,
  parameter int unsigned COEF_W   = 6,
  parameter int unsigned S_W      = 1,
  parameter bit          S_SIGNED = 1'b0,
  parameter int unsigned IDX_W    = 10
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [IDX_W-1:0]                a_idx,
  input  logic [LANES*COEF_W-1:0]         a_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [IDX_W-1:0]                s_idx,
  input  logic [LANES*S_W-1:0]            s_data,
  output logic                            b_valid,
  input  logic                            b_ready,
  output logic [IDX_W:0]                  b_idx,
  output logic [(2*LANES-1)*COEF_W-1:0]   b_data,
  output logic                            b_last
);

  localparam int unsigned      TERMS    = 2*LANES - 1;
  localparam int unsigned      EXT_W    = (COEF_W > S_W) ? COEF_W : S_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - LANES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                    state;
  logic [LANES*COEF_W-1:0]   a_q;
  logic [IDX_W-1:0]          a_idx_q;
  logic [COEF_W-1:0]         pp_d [LANES][LANES];
  logic [COEF_W-1:0]         pp_q [LANES][LANES];
  logic [COEF_W-1:0]         c_d  [TERMS];
  logic [TERMS*COEF_W-1:0]   c_packed;
  logic                      v1;
  logic                      last1;
  logic [IDX_W:0]            idx1;
  logic                      advance;
  logic                      a_xfer;
  logic                      s_xfer;
  logic                      s_last;

  // Both stages move together; a full, unaccepted stage 2 freezes the whole pipe.
  assign advance = !b_valid || b_ready;
  assign a_ready = (state == IDLE);
  assign s_ready = (state == HOLD) && advance;
  assign a_xfer  = a_valid && a_ready;
  assign s_xfer  = s_valid && s_ready;
  assign s_last  = (s_idx == LAST_IDX);

  function automatic logic [COEF_W-1:0] ext_s(input logic [S_W-1:0] v);
    logic [EXT_W-1:0] w;
    if (S_SIGNED) w = EXT_W'($signed(v));
    else          w = EXT_W'(v);
    return w[COEF_W-1:0];
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        pp_d[i][j] = a_q[i*COEF_W +: COEF_W] * ext_s(s_data[j*S_W +: S_W]);
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < TERMS; k++) c_d[k] = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        c_d[i+j] = c_d[i+j] + pp_q[i][j];
      end
    end
    c_packed = '0;
    for (int unsigned k = 0; k < TERMS; k++) c_packed[k*COEF_W +: COEF_W] = c_d[k];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      a_q     <= '0;
      a_idx_q <= '0;
      v1      <= 1'b0;
      idx1    <= '0;
      last1   <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        for (int unsigned j = 0; j < LANES; j++) pp_q[i][j] <= '0;
      end
      b_valid <= 1'b0;
      b_idx   <= '0;
      b_data  <= '0;
      b_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (a_xfer) begin
          a_q     <= a_data;
          a_idx_q <= a_idx;
          state   <= HOLD;
        end
        HOLD: if (s_xfer && s_last) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (advance) begin
        v1 <= s_xfer;
        if (s_xfer) begin
          pp_q  <= pp_d;
          idx1  <= {1'b0, a_idx_q} + {1'b0, s_idx};
          last1 <= s_last;
        end
        b_valid <= v1;
        if (v1) begin
          b_data <= c_packed;
          b_idx  <= idx1;
          b_last <= last1;
        end
      end
    end
  end

endmodule

// File: tb/tb_packed_poly_mac_stream.sv
// Bench for packed_poly_mac_stream: an unsigned default instance and a signed S_W=2 instance share
// one stimulus bus selected by sel; results are checked against an integer polynomial model.
module tb_packed_poly_mac_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        a_valid = 1'b0;
  logic [9:0]  a_idx = '0;
  logic [23:0] a_data = '0;
  logic        s_valid = 1'b0;
  logic [9:0]  s_idx = '0;
  logic [7:0]  s_data = '0;
  logic        b_ready = 1'b1;

  logic        a_ready_u, s_ready_u, b_valid_u, b_last_u;
  logic [10:0] b_idx_u;
  logic [41:0] b_data_u;
  logic        a_ready_s, s_ready_s, b_valid_s, b_last_s;
  logic [10:0] b_idx_s;
  logic [41:0] b_data_s;

  logic        a_rdy, s_rdy, b_valid_o, b_last_o;
  logic [10:0] b_idx_o;
  logic [41:0] b_data_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [10:0] idx;
    logic [41:0] data;
    logic        last;
  } exp_t;

  always #5 clk = ~clk;

  packed_poly_mac_stream #(
    .DEPTH(784), .LANES(4), .COEF_W(6), .S_W(1), .S_SIGNED(1'b0), .IDX_W(10)
  ) dut_u (
    .clk_in(clk), .rst_in(rst_n),
    .a_valid(a_valid & ~sel), .a_ready(a_ready_u), .a_idx(a_idx), .a_data(a_data),
    .s_valid(s_valid & ~sel), .s_ready(s_ready_u), .s_idx(s_idx), .s_data(s_data[3:0]),
    .b_valid(b_valid_u), .b_ready(b_ready), .b_idx(b_idx_u), .b_data(b_data_u), .b_last(b_last_u)
  );

  packed_poly_mac_stream #(
    .DEPTH(784), .LANES(4), .COEF_W(6), .S_W(2), .S_SIGNED(1'b1), .IDX_W(10)
  ) dut_s (
    .clk_in(clk), .rst_in(rst_n),
    .a_valid(a_valid & sel), .a_ready(a_ready_s), .a_idx(a_idx), .a_data(a_data),
    .s_valid(s_valid & sel), .s_ready(s_ready_s), .s_idx(s_idx), .s_data(s_data),
    .b_valid(b_valid_s), .b_ready(b_ready), .b_idx(b_idx_s), .b_data(b_data_s), .b_last(b_last_s)
  );

  assign a_rdy     = sel ? a_ready_s : a_ready_u;
  assign s_rdy     = sel ? s_ready_s : s_ready_u;
  assign b_valid_o = sel ? b_valid_s : b_valid_u;
  assign b_last_o  = sel ? b_last_s  : b_last_u;
  assign b_idx_o   = sel ? b_idx_s   : b_idx_u;
  assign b_data_o  = sel ? b_data_s  : b_data_u;

  // Schoolbook product of two 4-term polynomials in plain integers, reduced mod 64 at the end.
  function automatic logic [41:0] poly(input logic [23:0] a, input logic [7:0] s,
                                       input int sw, input bit sgn);
    int c[7];
    int av, sv;
    logic [7:0] mask;
    logic [41:0] r;
    foreach (c[k]) c[k] = 0;
    mask = (8'd1 << sw) - 8'd1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        av = int'(a[i*6 +: 6]);
        sv = int'((s >> (j*sw)) & mask);
        if (sgn && sv >= (1 << (sw-1))) sv = sv - (1 << sw);
        c[i+j] = c[i+j] + av*sv;
      end
    end
    r = '0;
    for (int k = 0; k < 7; k++) r[k*6 +: 6] = 6'(((c[k] % 64) + 64) % 64);
    return r;
  endfunction

  task automatic load_a(input logic [23:0] d, input logic [9:0] idx, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_data = d; a_idx = idx;
    #1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = a_rdy;
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
  endtask

  // lat = edges from the transfer edge (1) to first b_valid sample; -1 on timeout.
  task automatic send_s(input logic [7:0] d, input logic [9:0] idx, input logic br, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    @(negedge clk);
    b_ready = br; s_valid = 1'b1; s_data = d; s_idx = idx;
    #1;
    for (int n = 0; n < 20 && !got; n++) begin
      got = s_rdy;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (got) begin
      for (int n = 1; n <= 8; n++) begin
        if (b_valid_o) begin lat = n; break; end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b want 1", a_rdy); end
    checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", s_rdy); end
    checks++; if (b_valid_o !== 1'b0 || b_valid_s !== 1'b0) begin errors++; $display("FAIL reset_b_valid got %b/%b want 0", b_valid_o, b_valid_s); end
    checks++; if (b_last_o !== 1'b0) begin errors++; $display("FAIL reset_b_last got %b want 0", b_last_o); end
    checks++; if (b_idx_o !== 11'd0) begin errors++; $display("FAIL reset_b_idx got %0d want 0", b_idx_o); end
    checks++; if (b_data_o !== 42'd0) begin errors++; $display("FAIL reset_b_data got %h want 0", b_data_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h0f; s_idx = 10'd0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL idle_s_ready got %b want 0", s_rdy); end
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b_valid_o !== 1'b0) begin errors++; $display("FAIL idle_s_ignored b_valid got %b want 0", b_valid_o); end
  endtask

  task automatic test_basic();
    bit ok; int lat;
    logic [23:0] a;
    sel = 1'b0;
    a = {6'd4, 6'd3, 6'd2, 6'd1};
    load_a(a, 10'd8, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_load_a timeout got 0 want 1"); end
    send_s(8'h0f, 10'd0, 1'b1, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d want 2", lat); end
    checks++; if (b_data_o !== {6'd4, 6'd7, 6'd9, 6'd10, 6'd6, 6'd3, 6'd1}) begin errors++; $display("FAIL basic_data got %h want %h", b_data_o, {6'd4, 6'd7, 6'd9, 6'd10, 6'd6, 6'd3, 6'd1}); end
    checks++; if (b_idx_o !== 11'd8) begin errors++; $display("FAIL basic_idx got %0d want 8", b_idx_o); end
    checks++; if (b_last_o !== 1'b0) begin errors++; $display("FAIL basic_last got %b want 0", b_last_o); end
  endtask

  task automatic test_single_tap();
    int lat;
    logic [23:0] a;
    a = {6'd4, 6'd3, 6'd2, 6'd1};
    send_s(8'h01, 10'd4, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o !== poly(a, 8'h01, 1, 1'b0)) begin errors++; $display("FAIL tap0_data got %h lat %0d want %h lat 2", b_data_o, lat, poly(a, 8'h01, 1, 1'b0)); end
    checks++; if (b_idx_o !== 11'd12) begin errors++; $display("FAIL tap0_idx got %0d want 12", b_idx_o); end
    send_s(8'h08, 10'd780, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o !== poly(a, 8'h08, 1, 1'b0)) begin errors++; $display("FAIL tap3_data got %h lat %0d want %h lat 2", b_data_o, lat, poly(a, 8'h08, 1, 1'b0)); end
    checks++; if (b_last_o !== 1'b1 || b_idx_o !== 11'd788) begin errors++; $display("FAIL tap3_last_idx got %b/%0d want 1/788", b_last_o, b_idx_o); end
    checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL tap3_a_ready got %b want 1", a_rdy); end
  endtask

  task automatic test_wrap();
    bit ok; int lat;
    load_a({4{6'd63}}, 10'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_load_a timeout got 0 want 1"); end
    send_s(8'h0f, 10'd780, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o !== {6'd63, 6'd62, 6'd61, 6'd60, 6'd61, 6'd62, 6'd63}) begin errors++; $display("FAIL wrap_data got %h lat %0d want %h lat 2", b_data_o, lat, {6'd63, 6'd62, 6'd61, 6'd60, 6'd61, 6'd62, 6'd63}); end
  endtask

  task automatic test_signed();
    bit ok; int lat;
    logic [23:0] a;
    logic [7:0] s;
    sel = 1'b1;
    a = 24'd1;
    load_a(a, 10'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL signed_load_a timeout got 0 want 1"); end
    send_s(8'b0000_0011, 10'd0, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o[5:0] !== 6'd63) begin errors++; $display("FAIL signed_neg1 got c0 %0d lat %0d want 63 lat 2", b_data_o[5:0], lat); end
    send_s(8'b0000_0001, 10'd4, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o[5:0] !== 6'd1) begin errors++; $display("FAIL signed_pos1 got c0 %0d lat %0d want 1 lat 2", b_data_o[5:0], lat); end
    s = 8'($urandom);
    send_s(s, 10'd780, 1'b1, lat);
    checks++; if (lat !== 2 || b_data_o !== poly(a, s, 2, 1'b1)) begin errors++; $display("FAIL signed_rand0 got %h want %h", b_data_o, poly(a, s, 2, 1'b1)); end
    for (int n = 0; n < 3; n++) begin
      a = 24'($urandom);
      s = 8'($urandom);
      load_a(a, 10'(n), ok);
      send_s(s, 10'd780, 1'b1, lat);
      checks++; if (!ok || lat !== 2 || b_data_o !== poly(a, s, 2, 1'b1)) begin errors++; $display("FAIL signed_rand got %h lat %0d want %h lat 2", b_data_o, lat, poly(a, s, 2, 1'b1)); end
      checks++; if (b_last_o !== 1'b1 || b_idx_o !== 11'(780 + n)) begin errors++; $display("FAIL signed_rand_idx got %b/%0d want 1/%0d", b_last_o, b_idx_o, 780 + n); end
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_back_to_back_sweep();
    bit ok, br, stalled, final_seen;
    int k, cyc;
    logic [23:0] a;
    logic [9:0] ai;
    logic [3:0] sd;
    exp_t q[$];
    exp_t e;
    br = 1'b0; stalled = 1'b0; final_seen = 1'b0; k = 0; cyc = 0;
    a = 24'($urandom);
    ai = 10'($urandom);
    sd = 4'($urandom);
    load_a(a, ai, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sweep_load_a timeout got 0 want 1"); end
    while ((k < 196 || q.size() != 0 || b_valid_o) && cyc < 3000) begin
      @(negedge clk);
      if (final_seen) begin
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL sweep_a_ready_after_last got %b want 1", a_rdy); end
        final_seen = 1'b0;
      end
      br = ~br;
      b_ready = br;
      s_valid = (k < 196) && ($urandom_range(0, 3) != 0);
      s_idx = 10'(4*k);
      s_data = {4'b0, sd};
      #1;
      if (stalled) begin
        checks++; if (b_valid_o !== 1'b1) begin errors++; $display("FAIL sweep_stall_valid got %b want 1", b_valid_o); end
      end
      if (b_valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sweep_extra_product got idx %0d want none", b_idx_o);
        end else if (b_idx_o !== q[0].idx || b_data_o !== q[0].data || b_last_o !== q[0].last) begin
          errors++; $display("FAIL sweep_product got %0d/%h/%b want %0d/%h/%b", b_idx_o, b_data_o, b_last_o, q[0].idx, q[0].data, q[0].last);
        end
        if (b_ready && q.size() != 0) void'(q.pop_front());
      end
      stalled = b_valid_o && !b_ready;
      if (s_valid && s_rdy) begin
        e.idx  = 11'(ai) + 11'(4*k);
        e.data = poly(a, {4'b0, sd}, 1, 1'b0);
        e.last = (k == 195);
        q.push_back(e);
        if (k == 195) begin
          checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL sweep_a_ready_at_last got %b want 0", a_rdy); end
          final_seen = 1'b1;
        end
        k++;
        sd = 4'($urandom);
      end
      cyc++;
    end
    s_valid = 1'b0;
    b_ready = 1'b1;
    checks++; if (k != 196 || q.size() != 0) begin errors++; $display("FAIL sweep_complete got %0d sent %0d pending want 196 sent 0 pending", k, q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat;
    logic [23:0] a;
    logic [3:0] s;
    load_a(24'($urandom), 10'd5, ok);
    send_s(8'h0b, 10'd0, 1'b0, lat);
    checks++; if (!ok || lat !== 2) begin errors++; $display("FAIL rstmid_setup got lat %0d want 2", lat); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b_valid_o !== 1'b0 || a_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_async got b_valid %b a_ready %b want 0 1", b_valid_o, a_rdy); end
    checks++; if (b_data_o !== 42'd0 || s_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_clear got %h/%b want 0/0", b_data_o, s_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    b_ready = 1'b1;
    a = 24'($urandom);
    s = 4'($urandom);
    load_a(a, 10'd100, ok);
    send_s({4'b0, s}, 10'd200, 1'b1, lat);
    checks++; if (!ok || lat !== 2 || b_data_o !== poly(a, {4'b0, s}, 1, 1'b0)) begin errors++; $display("FAIL rstmid_after got %h lat %0d want %h lat 2", b_data_o, lat, poly(a, {4'b0, s}, 1, 1'b0)); end
    checks++; if (b_idx_o !== 11'd300 || b_last_o !== 1'b0) begin errors++; $display("FAIL rstmid_after_idx got %0d/%b want 300/0", b_idx_o, b_last_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_tap();
    test_wrap();
    test_signed();
    test_back_to_back_sweep();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packed_poly_mac_stream.md
Name: packed_poly_mac_stream

Overview:
- Parametrised successor to the packed public/private multiply stage in the LWE encrypt datapath.
- Latches one packed public-key chunk A of LANES coefficients, then streams secret chunks s against it.
- For every s chunk it emits the full (2*LANES-1)-term negacyclic-free polynomial product mod 2^COEF_W, tagged with the summed index, to the downstream accumulator.
- Adds over the previous generation: full valid/ready backpressure on the output, a 2-stage pipeline, a signed-secret mode, and a sweep-end marker.

Parameters:
- DEPTH, 784, secret vector length; a sweep ends on the s chunk with s_idx == DEPTH-LANES.
- LANES, 4, coefficients per packed beat; DEPTH must be a multiple of LANES.
- COEF_W, 6, coefficient width; all arithmetic is mod 2^COEF_W.
- S_W, 1, secret coefficient width.
- S_SIGNED, 0, 0 = secret unsigned; 1 = secret two's complement, sign-extended before multiply.
- IDX_W, 10, index width.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-low reset
- a_valid  in  1  A chunk offered
- a_ready  out  1  block can take an A chunk
- a_idx  in  IDX_W  index of A chunk
- a_data  in  LANES*COEF_W  A coefficients, lane 0 in LSBs
- s_valid  in  1  s chunk offered
- s_ready  out  1  block can take an s chunk
- s_idx  in  IDX_W  index of s chunk
- s_data  in  LANES*S_W  s coefficients, lane 0 in LSBs
- b_valid  out  1  product valid
- b_ready  in  1  downstream accepts product
- b_idx  out  IDX_W+1  a_idx + s_idx, no truncation
- b_data  out  (2*LANES-1)*COEF_W  product coefficients c0 in LSBs
- b_last  out  1  product belongs to the final s chunk of the sweep

Behaviour:
- Reset: asynchronous on rst_in low, effective immediately.
  - Reset values: a_ready=1, s_ready=0, b_valid=0, b_last=0, b_idx=0, b_data=0.
  - State returns to IDLE and pipeline valids are cleared.
  - Any in-flight products are dropped.
- States: IDLE (no A held) and HOLD (A held).
- Transfers: an A transfer occurs when a_valid&&a_ready; an s transfer occurs when s_valid&&s_ready.
- IDLE:
  - a_ready=1, s_ready=0.
  - On an A transfer: latch a_data and a_idx, then go to HOLD.
- HOLD:
  - a_ready=0.
  - s_ready=1 whenever the pipeline can advance, i.e. stage 2 is empty or b_ready=1.
  - On an s transfer with s_idx==DEPTH-LANES: mark the beat last and return to IDLE next cycle. This gives one bubble before the next A transfer is possible.
- Pipeline stage 1: registers the LANES*LANES partial products a_i*s_j, each truncated to COEF_W bits, plus the index sum and the last flag.
- Pipeline stage 2: registers c_k = sum over i+j=k of a_i*s_j mod 2^COEF_W, for k = 0..2*LANES-2.
- Latency: an s transfer at cycle N gives b_valid=1 at N+2 when there is no stall.
- Stall rule: when b_valid=1 and b_ready=0, stage 2 holds b_data, b_idx and b_last stable; stage 1 holds; s_ready=0.
- Throughput: one product per cycle sustained.
- b_valid falls the cycle after acceptance if no new data is behind it.
- S_SIGNED=1: s_j is sign-extended to COEF_W bits before multiply. With S_W=2, the value 2'b11 means -1, so its product is 2^COEF_W - a_i.
- An s_idx that is not a multiple of LANES is not checked; it is tagged through unchanged.
- s_valid while in IDLE is ignored; s_ready=0, so no transfer occurs.
- An A transfer and the final s transfer never coincide, because a_ready=0 in HOLD.

Test Plan:
- Unsigned basic, defaults: a_data coeffs (1,2,3,4), a_idx=8; then s_data=4'b1111, s_idx=0 -> b_data c0..c6 = (1,3,6,10,9,7,4), b_idx=8, b_last=0, and b_valid rises 2 cycles after the s transfer.
- Single tap: s=4'b0001 with the same A -> c = (1,2,3,4,0,0,0); s=4'b1000 -> c = (0,0,0,1,2,3,4).
- Wrap: all a_i=63, s=4'b1111 -> c = (63,62,61,60,61,62,63).
- Signed mode (S_W=2, S_SIGNED=1): a0=1, others 0, s0=2'b11 -> c0=63; s0=2'b01 -> c0=1.
- Sweep and backpressure: stream all 196 s chunks with b_ready toggling 1/0 every cycle.
  - Required: no product is lost or duplicated, outputs stay stable while stalled, and b_last=1 only on s_idx=780.
  - Required: a_ready rises one cycle after the final s transfer.
- Async reset mid-sweep: drop rst_in while b_valid=1 and stalled -> b_valid=0 and a_ready=1 immediately; after release, the next A/s pair produces correct results.
